// File: rtl/piso_shift_transmitter_if.sv
// Load handshake, bit strobe and serial output bundle for piso_shift_transmitter.
// master = word source / bit clock, slave = transmitter.
interface piso_shift_transmitter_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             frame_last;
    logic             done;

    modport master (
        output din,
        output load_valid,
        output shift_en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  frame_last,
        input  done
    );

    modport slave (
        input  din,
        input  load_valid,
        input  shift_en,
        output load_ready,
        output sout,
        output sout_valid,
        output frame_last,
        output done
    );
endinterface

// File: rtl/piso_shift_transmitter.sv
// Parallel-in serial-out transmitter with valid/ready load and bit strobe.
// Define PISO_PARITY_EN to append a parity bit (sense set by PARITY_ODD).
module piso_shift_transmitter #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_ODD = 0
) (
    input logic                   clk,
    input logic                   reset,
    piso_shift_transmitter_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("piso_shift_transmitter: illegal parameter value");
    end

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic             finish;
    logic             last_data;
    logic             ready_c;
    logic             valid_c;
    logic             last_c;
    logic [WIDTH-1:0] shifted;
`ifdef PISO_PARITY_EN
    logic             par_q;
    logic [WIDTH-1:0] par_word;
`endif

    assign last_data = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        valid_c    = 1'b0;
        last_c     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.load_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                valid_c = 1'b1;
`ifdef PISO_PARITY_EN
                if (bus.shift_en && last_data) begin
                    state_next = PARITY;
                end
`else
                last_c = last_data;
                if (bus.shift_en && last_data) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
                if (bus.shift_en) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Shifting toward the output end with zero fill leaves shreg clear at
    // frame end, so sout idles at 0 straight from the register.
    if (MSB_FIRST != 0) begin : g_msb
        assign shifted  = {shreg[WIDTH-2:0], 1'b0};
        assign bus.sout = shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
        assign par_word = {par_q, {(WIDTH-1){1'b0}}};
`endif
    end else begin : g_lsb
        assign shifted  = {1'b0, shreg[WIDTH-1:1]};
        assign bus.sout = shreg[0];
`ifdef PISO_PARITY_EN
        assign par_word = {{(WIDTH-1){1'b0}}, par_q};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            done_q <= finish;
            if (state == IDLE && bus.load_valid) begin
                shreg <= bus.din;
                cnt   <= '0;
`ifdef PISO_PARITY_EN
                par_q <= (^bus.din) ^ (PARITY_ODD != 0);
`endif
            end else if (state == SHIFT && bus.shift_en) begin
                if (last_data) begin
                    cnt <= '0;
`ifdef PISO_PARITY_EN
                    // Parity bit drops into the output slot as data runs out.
                    shreg <= par_word;
`else
                    shreg <= '0;
`endif
                end else begin
                    cnt   <= cnt + 1'b1;
                    shreg <= shifted;
                end
            end
`ifdef PISO_PARITY_EN
            else if (state == PARITY && bus.shift_en) begin
                shreg <= '0;
            end
`endif
        end
    end

    assign bus.load_ready = ready_c;
    assign bus.sout_valid = valid_c;
    assign bus.frame_last = last_c;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Directed bench: MSB-first and LSB-first instances, strobe pacing,
// busy loads, async mid-frame reset, parity bit when PISO_PARITY_EN set.
module tb_piso_shift_transmitter;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = 5;
    localparam logic [4:0] EXP_A_B = 5'b11101;
    localparam logic [4:0] EXP_B_B = 5'b01011;
    localparam logic [4:0] EXP_A_A = 5'b00101;
`else
    localparam int NB = 4;
    localparam logic [4:0] EXP_A_B = 5'b01101;
    localparam logic [4:0] EXP_B_B = 5'b01011;
    localparam logic [4:0] EXP_A_A = 5'b00101;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    piso_shift_transmitter_if #(.WIDTH(W)) ifa ();
    piso_shift_transmitter_if #(.WIDTH(W)) ifb ();

    piso_shift_transmitter #(
        .WIDTH(W), .MSB_FIRST(1), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );

    piso_shift_transmitter #(
        .WIDTH(W), .MSB_FIRST(0), .PARITY_ODD(1)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [W-1:0] d,
                         input logic lv, input logic se);
        if (sel) begin
            ifb.din = d; ifb.load_valid = lv; ifb.shift_en = se;
        end else begin
            ifa.din = d; ifa.load_valid = lv; ifa.shift_en = se;
        end
    endtask

    task automatic obs(input bit sel, output logic so, output logic sv,
                       output logic fl, output logic dn, output logic rdy);
        so  = sel ? ifb.sout       : ifa.sout;
        sv  = sel ? ifb.sout_valid : ifa.sout_valid;
        fl  = sel ? ifb.frame_last : ifa.frame_last;
        dn  = sel ? ifb.done       : ifa.done;
        rdy = sel ? ifb.load_ready : ifa.load_ready;
    endtask

    task automatic run_frame(input string tag, input bit sel,
                             input logic [W-1:0] d, input logic [4:0] exp,
                             input int per, input bit busy);
        logic so, sv, fl, dn, rdy, lv;
        drive(sel, d, 1'b1, 1'b0);
        obs(sel, so, sv, fl, dn, rdy);
        check({tag, " rdy0"}, rdy, 1'b1);
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            for (int h = 0; h < per; h++) begin
                lv = busy && i == 1 && h == 0;
                drive(sel, lv ? 4'h5 : d, lv, h == per - 1);
                obs(sel, so, sv, fl, dn, rdy);
                check($sformatf("%s b%0d.%0d sout", tag, i, h), so, exp[i]);
                check($sformatf("%s b%0d.%0d sv", tag, i, h), sv, 1'b1);
                check($sformatf("%s b%0d.%0d fl", tag, i, h), fl,
                      32'(i == NB - 1));
                check($sformatf("%s b%0d.%0d dn", tag, i, h), dn, 1'b0);
                check($sformatf("%s b%0d.%0d rdy", tag, i, h), rdy, 1'b0);
                @(negedge clk);
            end
        end
        drive(sel, d, 1'b0, 1'b0);
        obs(sel, so, sv, fl, dn, rdy);
        check({tag, " done"}, dn, 1'b1);
        check({tag, " rdy_end"}, rdy, 1'b1);
        check({tag, " sv_end"}, sv, 1'b0);
        check({tag, " so_end"}, so, 1'b0);
        @(negedge clk);
        obs(sel, so, sv, fl, dn, rdy);
        check({tag, " done_off"}, dn, 1'b0);
    endtask

    initial begin
        logic so, sv, fl, dn, rdy;
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            obs(s[0], so, sv, fl, dn, rdy);
            check($sformatf("rst%0d sout", s), so, 1'b0);
            check($sformatf("rst%0d sv", s), sv, 1'b0);
            check($sformatf("rst%0d fl", s), fl, 1'b0);
            check($sformatf("rst%0d dn", s), dn, 1'b0);
            check($sformatf("rst%0d rdy", s), rdy, 1'b1);
        end

        run_frame("msb_b", 1'b0, 4'b1011, EXP_A_B, 1, 1'b0);
        run_frame("lsb_b", 1'b1, 4'b1011, EXP_B_B, 3, 1'b0);
        run_frame("busy_a", 1'b0, 4'hA, EXP_A_A, 1, 1'b1);

        drive(1'b0, 4'b1011, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'b1011, 1'b0, 1'b1);
        @(negedge clk);
        obs(1'b0, so, sv, fl, dn, rdy);
        check("mid bit2 sout", so, 1'b0);
        check("mid bit2 sv", sv, 1'b1);
        #2 reset = 1'b0;
        #1;
        obs(1'b0, so, sv, fl, dn, rdy);
        check("mid rst sout", so, 1'b0);
        check("mid rst sv", sv, 1'b0);
        check("mid rst fl", fl, 1'b0);
        check("mid rst dn", dn, 1'b0);
        drive(1'b0, 4'b1011, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs(1'b0, so, sv, fl, dn, rdy);
            check($sformatf("post rst%0d dn", c), dn, 1'b0);
            check($sformatf("post rst%0d sv", c), sv, 1'b0);
            check($sformatf("post rst%0d rdy", c), rdy, 1'b1);
        end

        run_frame("again_b", 1'b0, 4'b1011, EXP_A_B, 1, 1'b0);
        run_frame("b2b_b", 1'b0, 4'b1011, EXP_A_B, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
